// File: rtl/suma_control_if.sv
// Keypad/adder/display bundle for suma_control.
interface suma_control_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [12:0] resultado;
  logic [11:0] num1;
  logic [11:0] num2;
  logic [12:0] result;
  logic        result_valid;
  logic [12:0] display;
  logic        busy;
  logic [1:0]  state;

  modport master (
    output key_valid, key_code, resultado,
    input  num1, num2, result, result_valid, display, busy, state
  );

  modport slave (
    input  key_valid, key_code, resultado,
    output num1, num2, result, result_valid, display, busy, state
  );
endinterface

// File: rtl/suma_control.sv
// Keypad calculator sequencer: builds two decimal operands, waits on the
// registered adder, then latches and shows the sum.
module suma_control #(
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned ADD_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  suma_control_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);
  localparam int unsigned WAIT_W = 3;
  localparam logic [3:0]  KEY_PLUS  = 4'hA;
  localparam logic [3:0]  KEY_EQ    = 4'hB;
  localparam logic [3:0]  KEY_CLEAR = 4'hC;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    WAIT_SUM = 2'd2,
    SHOW     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [11:0]       num1_q, num1_d;
  logic [11:0]       num2_q, num2_d;
  logic [12:0]       result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_q, busy_d;
  logic [12:0]       display_q, display_d;

  logic        is_digit;
  logic        cnt_full;
  logic [11:0] digit_ext;
  logic [11:0] acc1;
  logic [11:0] acc2;

  // operand*10 + d as (op<<3) + (op<<1) + d
  always_comb begin
    is_digit  = bus.key_valid && (bus.key_code <= 4'd9);
    cnt_full  = (cnt_q >= CNT_W'(DIGITS));
    digit_ext = 12'(bus.key_code);
    acc1      = {num1_q[8:0], 3'b000} + {num1_q[10:0], 1'b0} + digit_ext;
    acc2      = {num2_q[8:0], 3'b000} + {num2_q[10:0], 1'b0} + digit_ext;
  end

  always_comb begin
    state_d        = state_q;
    num1_d         = num1_q;
    num2_d         = num2_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    cnt_d          = cnt_q;
    wait_d         = wait_q;
    busy_d         = 1'b0;
    display_d      = 13'd0;

    unique case (state_q)
      ENTER_A: begin
        if (is_digit) begin
          if (!cnt_full) begin
            num1_d = acc1;
            cnt_d  = CNT_W'(cnt_q + 1'b1);
          end
        end else if (bus.key_valid && bus.key_code == KEY_PLUS) begin
          state_d = ENTER_B;
          cnt_d   = '0;
        end else if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
          num1_d = '0;
          cnt_d  = '0;
        end
      end
      ENTER_B: begin
        if (is_digit) begin
          if (!cnt_full) begin
            num2_d = acc2;
            cnt_d  = CNT_W'(cnt_q + 1'b1);
          end
        end else if (bus.key_valid && bus.key_code == KEY_EQ) begin
          state_d = WAIT_SUM;
          wait_d  = WAIT_W'(ADD_LATENCY);
        end else if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
          num1_d  = '0;
          num2_d  = '0;
          cnt_d   = '0;
          state_d = ENTER_A;
        end
      end
      WAIT_SUM: begin
        if (wait_q == '0) begin
          result_d       = bus.resultado;
          result_valid_d = 1'b1;
          state_d        = SHOW;
        end else begin
          wait_d = WAIT_W'(wait_q - 1'b1);
        end
      end
      SHOW: begin
        if (is_digit) begin
          num1_d         = digit_ext;
          num2_d         = '0;
          cnt_d          = CNT_W'(1);
          result_valid_d = 1'b0;
          state_d        = ENTER_A;
        end else if (bus.key_valid && bus.key_code == KEY_CLEAR) begin
          num1_d         = '0;
          num2_d         = '0;
          result_d       = '0;
          result_valid_d = 1'b0;
          cnt_d          = '0;
          state_d        = ENTER_A;
        end
      end
    endcase

    // Status outputs follow the state being entered so they stay aligned with it
    busy_d = (state_d == WAIT_SUM);
    unique case (state_d)
      ENTER_A:  display_d = 13'(num1_d);
      ENTER_B,
      WAIT_SUM: display_d = 13'(num2_d);
      SHOW:     display_d = result_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ENTER_A;
      num1_q         <= '0;
      num2_q         <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      cnt_q          <= '0;
      wait_q         <= '0;
      busy_q         <= 1'b0;
      display_q      <= '0;
    end else begin
      state_q        <= state_d;
      num1_q         <= num1_d;
      num2_q         <= num2_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      cnt_q          <= cnt_d;
      wait_q         <= wait_d;
      busy_q         <= busy_d;
      display_q      <= display_d;
    end
  end

  assign bus.num1         = num1_q;
  assign bus.num2         = num2_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.display      = display_q;
  assign bus.busy         = busy_q;
  assign bus.state        = state_q;

endmodule

// File: doc/suma_control.md
Name: suma_control

Overview:
Sequencer for the `suma_aritmetica` registered 12-bit adder in the keypad calculator.
- Accumulates decimal keypad digits into operand A, then operand B.
- On '=' holds both operands stable on `num1`/`num2` and waits a fixed adder latency.
- Latches the adder's 13-bit `resultado` and presents it for display.
- Sits between the keypad decoder and the adder/display path, 27 MHz domain.

Parameters:
- DIGITS, 3, maximum decimal digits per operand (1..3; 999 max fits 12 bits).
- ADD_LATENCY, 1, adder clock cycles from stable operands to valid `resultado` (0..7).

Ports:
- clk  in  1  system clock, 27 MHz
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on rising `clk`
- key_valid  in  1  single-cycle strobe, `key_code` valid
- key_code  in  4  0-9 = digit, 0xA = '+', 0xB = '=', 0xC = clear, 0xD-0xF = ignored
- resultado  in  13  sum from adder
- num1  out  12  operand A to adder
- num2  out  12  operand B to adder
- result  out  13  latched sum
- result_valid  out  1  `result` holds a completed sum
- display  out  13  value to show
- busy  out  1  waiting on adder
- state  out  2  current FSM state

Behaviour:
Reset (`rst` = 0 at rising edge):
- `state` = ENTER_A; `num1` = `num2` = `result` = 0; `result_valid` = 0; digit count = 0; wait counter = 0.
- Reset overrides any simultaneous key.
- Reset in any state aborts the operation, including mid-wait.

General rules:
- All registers update on rising `clk` only.
- No action when `key_valid` = 0.
- Codes 0xD-0xF are ignored in every state.

Digit accumulate (digit d):
- If digit count < DIGITS: operand <= operand*10 + d (12-bit; *10 computed as shift-add), count += 1.
- Otherwise the digit is dropped and the operand is unchanged.

State encoding: ENTER_A = 0, ENTER_B = 1, WAIT_SUM = 2, SHOW = 3.

ENTER_A:
- digit: accumulate into `num1`.
- '+': -> ENTER_B, count = 0 (A = 0 is allowed if no digits were entered).
- '=': ignored.
- clear: `num1` = 0, count = 0.

ENTER_B:
- digit: accumulate into `num2`.
- '=': -> WAIT_SUM, wait counter <= ADD_LATENCY.
- '+': ignored.
- clear: `num1` = `num2` = 0, count = 0, -> ENTER_A.

WAIT_SUM:
- All keys ignored; `num1`/`num2` held constant.
- Each edge: if counter == 0, then `result` <= `resultado`, `result_valid` <= 1, -> SHOW; else counter -= 1.
- Timing: '=' accepted at edge N gives `result_valid` = 1 after edge N+ADD_LATENCY+1.

SHOW:
- digit d: `num1` = d, `num2` = 0, count = 1, `result_valid` = 0, -> ENTER_A.
- clear: all zero, -> ENTER_A.
- '+' and '=': ignored (no chaining; result may exceed 999).

Registered outputs:
- `busy` = (`state` == WAIT_SUM).
- `display` = zero-extended `num1` in ENTER_A, zero-extended `num2` in ENTER_B and WAIT_SUM, `result` in SHOW.

Width rules:
- Operands are never above 999.
- Sum is at most 1998 and fits 13 bits; no overflow is possible.

Test Plan:
- Keys 1,2,3,+,4,5,6,= with a real `suma_aritmetica` -> `num1` = 123, `num2` = 456; `result` = 579 with `result_valid` = 1 exactly ADD_LATENCY+1 cycles after '='; `display` = 579.
- 7,8,9,+,9,8,7,= -> `result` = 1776. Then 9,9,9,+,1,= -> first digit 9 leaves SHOW with `num1` = 9; final `result` = 1000.
- 1,2,3,4 in ENTER_A -> `num1` = 123, 4th digit dropped. Then +,= -> `result` = 123.
- 5,+,6,C -> `state` = 0, `num1` = `num2` = 0; 0xE and '=' keys in ENTER_A leave all outputs unchanged.
- '=' accepted, then `rst` = 0 during WAIT_SUM -> next edge `state` = 0, `busy` = 0, `result_valid` = 0, all values 0. Keys pressed during WAIT_SUM (no reset) have no effect.
- Simultaneous `rst` = 0 and `key_valid` with digit 7 -> `num1` = 0 (reset wins).
